// File: rtl/my_divider_if.sv
// my_divider_if: start/operand request and result bundle for the sequential divider.
// Ports: start, dividend, divisor (requester -> divider); busy, done, quotient, remainder, div_by_zero (divider -> requester).
// Modports: master (requester side), slave (divider side).
interface my_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/my_divider.sv
// my_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done is high in the cycle after edge E(WIDTH) following the start edge E0; start is accepted only in IDLE/DONE.
// Backpressure: none; start during RUN is ignored, and start held in the done cycle chains the next division.
// Ports: clk, rst (sync, active-high), bus (my_divider_if.slave: start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out).
// Optional feature: define DIV_ZERO_DETECT_EN to finish a zero-divisor request immediately with div_by_zero=1.
module my_divider #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  my_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem_q;    // partial remainder between steps
  logic [WIDTH-1:0] dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;

  logic             accept;
  logic             zero_skip;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] work_n;
  logic [WIDTH-1:0] rem_n;

  assign accept = (state_q != RUN) && bus.start;

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;
  assign zero_skip       = (bus.divisor == '0);
  assign bus.div_by_zero = dbz_q;
`else
  assign zero_skip       = 1'b0;
  assign bus.div_by_zero = 1'b0;
`endif

  // One restoring step. The partial remainder is WIDTH+1 bits only after the
  // shift: between steps it is always below the divisor (or, for a zero
  // divisor, holds dividend bits), so its top bit is zero and is not stored.
  // When the trial goes negative the shifted value was below the divisor,
  // so its top bit is zero too and the low WIDTH bits are exact.
  always_comb begin
    shifted = {rem_q, work_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    rem_n   = shifted[WIDTH-1:0];
    work_n  = {work_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_n  = trial[WIDTH-1:0];
      work_n = {work_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) state_d = zero_skip ? DONE : RUN;
        else           state_d = IDLE;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remd_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q  <= 1'b0;
`endif
    end else if (accept) begin
      work_q <= bus.dividend;
      rem_q  <= '0;
      dvsr_q <= bus.divisor;
      cnt_q  <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
      // Zero divisor completes on the start edge with the same values the
      // full algorithm would produce.
      if (zero_skip) begin
        quot_q <= '1;
        remd_q <= bus.dividend;
        dbz_q  <= 1'b1;
      end
`endif
    end else if (state_q == RUN) begin
      work_q <= work_n;
      rem_q  <= rem_n;
      if (cnt_q == '0) begin
        quot_q <= work_n;
        remd_q <= rem_n;
`ifdef DIV_ZERO_DETECT_EN
        dbz_q  <= 1'b0;
`endif
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remd_q;

endmodule

// File: tb/tb_my_divider.sv
// tb_my_divider: directed, random and exhaustive checks of my_divider at WIDTH=4
// against an arithmetic reference (a/b, a%b, zero-divisor rule) and expected timing.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_my_divider;

  localparam int          W    = 4;
  localparam logic [31:0] ONES = (32'd1 << W) - 32'd1;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  my_divider_if #(.WIDTH(W)) bus ();

  my_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge (E0).
  task automatic issue(input int a, input int b);
    bus.dividend = a[W-1:0];
    bus.divisor  = b[W-1:0];
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Called c0 cycles after E0; waits (bounded) for done and checks timing and results.
  task automatic wait_done(input int a, input int b, input int c0, output int done_cyc);
    int lat;
    int c;
    logic [31:0] eq, er;
    lat = (b == 0 && DZ) ? 0 : W;
    eq  = (b == 0) ? ONES : 32'(a / b);
    er  = (b == 0) ? 32'(a) : 32'(a % b);
    c   = c0;
    while (bus.done !== 1'b1 && c < 3 * W + 4) begin
      chk("busy_in_run", {31'd0, bus.busy}, 32'd1);
      tick();
      c++;
    end
    chk("latency", 32'(c), 32'(lat));
    chk("done", {31'd0, bus.done}, 32'd1);
    chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
    chk("quotient", {28'd0, bus.quotient}, eq);
    chk("remainder", {28'd0, bus.remainder}, er);
    chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, (DZ && b == 0)});
    done_cyc = cyc;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_quotient"}, {28'd0, bus.quotient}, 32'd0);
    chk({tag, "_remainder"}, {28'd0, bus.remainder}, 32'd0);
    chk({tag, "_div_by_zero"}, {31'd0, bus.div_by_zero}, 32'd0);
  endtask

  // Single isolated operation: done must be one cycle long and results held afterwards.
  task automatic one_op(input int a, input int b);
    int dc;
    logic [31:0] eq;
    eq = (b == 0) ? ONES : 32'(a / b);
    issue(a, b);
    wait_done(a, b, 0, dc);
    tick();
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("quotient_held", {28'd0, bus.quotient}, eq);
  endtask

  initial begin
    int d1, d2, prev, dc, ndone, a, b;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    check_cleared("reset");
    rst = 1'b0;
    tick();

    // Directed cases, including boundaries and the zero divisor.
    one_op(13, 3);
    one_op(15, 1);
    one_op(5, 7);
    one_op(0, 5);
    one_op(15, 15);
    one_op(9, 0);

    // Start during RUN is ignored; start held in the done cycle chains.
    issue(13, 3);
    tick();
    bus.start    = 1'b1;
    bus.dividend = 4'd7;
    bus.divisor  = 4'd2;
    tick();
    bus.start    = 1'b0;
    wait_done(13, 3, 2, d1);
    issue(7, 2);
    wait_done(7, 2, 0, d2);
    chk("b2b_spacing", 32'(d2 - d1), 32'(W + 1));
    tick();

    // Reset in the second RUN cycle discards the division.
    issue(14, 4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("mid_run_reset");
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'd0);

    // Random operands, random gaps (zero gap means back-to-back).
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, ONES));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, ONES));
      issue(a, b);
      wait_done(a, b, 0, dc);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
      end
    end
    tick();

    // Exhaustive, back-to-back.
    prev = 0;
    for (int x = 0; x <= int'(ONES); x++) begin
      for (int y = 0; y <= int'(ONES); y++) begin
        issue(x, y);
        wait_done(x, y, 0, dc);
        if (x != 0 || y != 0)
          chk("exh_spacing", 32'(dc - prev), 32'(((y == 0 && DZ) ? 0 : W) + 1));
        prev = dc;
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
